answer_responder: RTL and testbench

ANSWER_RESPONDER -- requirements
Module: answer_responder

---
 rtl/error_check_pkg.sv | 16 +
 rtl/question_fifo.sv | 59 +++++
 rtl/answer_responder.sv | 144 ++++++++++++++
 tb/tb_answer_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/error_check_pkg.sv
// Shared definitions for the answer responder: FSM encoding, data width and
// parameter defaults.
package error_check_pkg;

    localparam int DATA_W              = 4;
    localparam int FIFO_DEPTH_DEFAULT  = 4;
    localparam int RESP_DELAY_DEFAULT  = 2;
    localparam int STALL_LIMIT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        PRESENT = 2'b10
    } state_t;

endpackage

// File: rtl/question_fifo.sv
// Power-of-two circular FIFO holding questions until the responder FSM pops them.
// Pointers wrap naturally because DEPTH is a power of two.
module question_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/answer_responder.sv
// Queues 4-bit questions, computes each answer after a fixed delay and presents it
// on a valid/ready handshake, dropping answers that stall for too long.
module answer_responder
    import error_check_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int RESP_DELAY  = RESP_DELAY_DEFAULT,
    parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              q_valid,
    input  logic [DATA_W-1:0] q_data,
    output logic              q_ready,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_data,
    input  logic              a_ready,
    input  logic              corrupt,
    output logic              busy,
    output logic [7:0]        answered_count,
    output logic              stall_err
);

    localparam logic [3:0] DELAY_LOAD = 4'(RESP_DELAY - 1);
    localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

    logic [1:0]        rst_sync;
    logic              fsm_rst_n;
    state_t            state, state_next;
    logic [3:0]        delay_cnt, delay_next;
    logic [7:0]        stall_cnt, stall_next;
    logic [DATA_W-1:0] ans_reg, ans_next;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] mapped;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              handshake;
    logic              drop;

    // Assertion is immediate; release reaches the FSM only after two clean edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign fsm_rst_n = rst_sync[1];

    question_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_valid & q_ready),
        .push_data (q_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mapped = {head_data[2] ^ head_data[3],
                     head_data[1] ^ head_data[2],
                     head_data[0] ^ head_data[1],
                     ~head_data[0]};

    always_comb begin
        state_next = state;
        delay_next = delay_cnt;
        stall_next = stall_cnt;
        ans_next   = ans_reg;
        pop        = 1'b0;
        handshake  = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && fsm_rst_n) begin
                    pop        = 1'b1;
                    ans_next   = mapped ^ {{(DATA_W - 1){1'b0}}, corrupt};
                    delay_next = DELAY_LOAD;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (delay_cnt == 4'd0) begin
                    stall_next = 8'd0;
                    state_next = PRESENT;
                end else begin
                    delay_next = delay_cnt - 4'd1;
                end
            end
            PRESENT: begin
                if (a_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end else if (stall_cnt == STALL_LAST) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_next = stall_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state     <= IDLE;
            delay_cnt <= 4'd0;
            stall_cnt <= 8'd0;
            ans_reg   <= '0;
        end else begin
            state     <= state_next;
            delay_cnt <= delay_next;
            stall_cnt <= stall_next;
            ans_reg   <= ans_next;
        end
    end

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            answered_count <= 8'd0;
            stall_err      <= 1'b0;
        end else begin
            if (handshake && answered_count != 8'hFF) begin
                answered_count <= answered_count + 8'd1;
            end
            if (drop) begin
                stall_err <= 1'b1;
            end
        end
    end

    assign q_ready = ~fifo_full;
    assign a_valid = (state == PRESENT);
    assign a_data  = a_valid ? ans_reg : '0;
    assign busy    = ~fifo_empty | (state != IDLE);

endmodule

// File: tb/tb_answer_responder.sv
// Self-checking bench for answer_responder: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_answer_responder;
    import error_check_pkg::*;

    localparam int DEPTH = 4;
    localparam int DELAY = 2;
    localparam int LIMIT = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       q_valid = 1'b0;
    logic [3:0] q_data  = 4'd0;
    logic       a_ready = 1'b0;
    logic       corrupt = 1'b0;
    logic       q_ready;
    logic       a_valid;
    logic [3:0] a_data;
    logic       busy;
    logic [7:0] answered_count;
    logic       stall_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: questions waiting, the answer in flight and its timing.
    logic [3:0] m_fifo[$];
    bit         m_inflight;
    logic [3:0] m_ans;
    int         m_pres_edge;
    int         m_stall;
    int         m_count;
    int         m_hs;
    bit         m_err;
    int         m_hold;
    int         edge_n = 0;
    bit         m_pushed;
    logic [3:0] last_hs_data;

    always #5 clk = ~clk;

    answer_responder #(
        .FIFO_DEPTH  (DEPTH),
        .RESP_DELAY  (DELAY),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .q_valid        (q_valid),
        .q_data         (q_data),
        .q_ready        (q_ready),
        .a_valid        (a_valid),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .corrupt        (corrupt),
        .busy           (busy),
        .answered_count (answered_count),
        .stall_err      (stall_err)
    );

    function automatic logic [3:0] ref_answer(logic [3:0] q, logic c);
        logic [3:0] a;
        a[0] = ~q[0] ^ c;
        for (int i = 1; i < 4; i++) a[i] = q[i-1] ^ q[i];
        return a;
    endfunction

    task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic timeout_fail(string tag);
        compared++;
        mismatched++;
        $error("[TB] FAIL %s: timed out waiting (edge %0d)", tag, edge_n);
    endtask

    task automatic reset_model();
        m_fifo.delete();
        m_inflight = 0;
        m_stall    = 0;
        m_count    = 0;
        m_hs       = 0;
        m_err      = 0;
        m_hold     = 2;
    endtask

    task automatic check_all();
        bit pres;
        pres = m_inflight && (edge_n >= m_pres_edge);
        check_output("q_ready", q_ready, m_fifo.size() < DEPTH);
        check_output("a_valid", a_valid, pres);
        check_output("a_data", a_data, pres ? m_ans : 4'd0);
        check_output("busy", busy, (m_fifo.size() != 0) || m_inflight);
        check_output("answered_count", answered_count, m_count);
        check_output("stall_err", stall_err, m_err);
    endtask

    // One clock cycle: check outputs, take the edge, advance the model.
    task automatic apply_stimulus();
        bit pres;
        bit can_push;
        check_all();
        pres     = m_inflight && (edge_n >= m_pres_edge);
        can_push = (m_fifo.size() < DEPTH);
        if (pres && a_ready) last_hs_data = a_data;
        @(posedge clk);
        edge_n++;
        m_pushed = 0;
        if (reset) begin
            if (pres) begin
                if (a_ready) begin
                    m_inflight = 0;
                    m_hs++;
                    if (m_count < 255) m_count++;
                end else begin
                    m_stall++;
                    if (m_stall == LIMIT) begin
                        m_inflight = 0;
                        m_err      = 1;
                    end
                end
            end else if (!m_inflight && m_hold == 0 && m_fifo.size() > 0) begin
                m_ans       = ref_answer(m_fifo.pop_front(), corrupt);
                m_inflight  = 1;
                m_pres_edge = edge_n + DELAY;
                m_stall     = 0;
            end
            if (q_valid && can_push) begin
                m_fifo.push_back(q_data);
                m_pushed = 1;
            end
            if (m_hold > 0) m_hold--;
        end
        #1;
    endtask

    task automatic push_one(logic [3:0] d);
        q_valid = 1'b1;
        q_data  = d;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus();
            if (m_pushed) break;
        end
        q_valid = 1'b0;
        if (!m_pushed) timeout_fail("push_one");
    endtask

    task automatic run_idle();
        int n = 0;
        while ((m_fifo.size() > 0 || m_inflight) && n < 500) begin
            apply_stimulus();
            n++;
        end
        if (m_fifo.size() > 0 || m_inflight) timeout_fail("run_idle");
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        reset_model();
        check_all();
        check_output("rst.a_valid", a_valid, 1'b0);
        check_output("rst.busy", busy, 1'b0);
        check_output("rst.q_ready", q_ready, 1'b1);
        check_output("rst.count", answered_count, 8'd0);
    endtask

    initial begin
        logic [3:0] sweep_q[3];
        logic [3:0] sweep_a[3];
        int vcount;
        int n;

        #1 reset = 1'b0;
        #1 reset_model();
        check_output("por.a_data", a_data, 4'd0);
        check_output("por.stall_err", stall_err, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus();

        // Single question: latency and mapping of 0101.
        a_ready = 1'b1;
        push_one(4'b0101);
        apply_stimulus();
        apply_stimulus();
        check_output("lat.not_yet", a_valid, 1'b0);
        apply_stimulus();
        check_output("lat.valid", a_valid, 1'b1);
        check_output("lat.data", a_data, 4'b1110);
        run_idle();
        check_output("single.count", answered_count, 8'd1);

        // Mapping sweep, then a corrupted answer.
        sweep_q = '{4'b0000, 4'b1111, 4'b1010};
        sweep_a = '{4'b0001, 4'b0000, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            push_one(sweep_q[i]);
            run_idle();
            check_output("sweep.ans", last_hs_data, sweep_a[i]);
        end
        corrupt = 1'b1;
        push_one(4'b0000);
        run_idle();
        corrupt = 1'b0;
        check_output("corrupt.ans", last_hs_data, 4'b0000);

        // Stall: answer dropped after LIMIT cycles, count unchanged.
        check_output("stall.before", stall_err, 1'b0);
        a_ready = 1'b0;
        push_one(4'h3);
        vcount = 0;
        n = 0;
        while ((m_fifo.size() > 0 || m_inflight) && n < 50) begin
            apply_stimulus();
            if (a_valid) vcount++;
            n++;
        end
        check_output("stall.valid_cycles", vcount, LIMIT);
        check_output("stall.err", stall_err, 1'b1);
        check_output("stall.count", answered_count, 8'd5);
        check_output("stall.busy", busy, 1'b0);

        // Fill the FIFO with the checker not accepting.
        for (int i = 0; i < 5; i++) push_one(4'(i + 6));
        check_output("fill.full", q_ready, 1'b0);
        push_one(4'hB);
        a_ready = 1'b1;
        run_idle();

        // Reset while presenting with two questions queued.
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(4'(i + 1));
        n = 0;
        while (!(m_inflight && edge_n >= m_pres_edge) && n < 20) begin
            apply_stimulus();
            n++;
        end
        check_output("midrst.queued", m_fifo.size() >= 2, 1'b1);
        check_output("midrst.presenting", a_valid, 1'b1);
        async_reset();
        q_valid = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus();
        q_valid = 1'b0;
        reset   = 1'b1;
        a_ready = 1'b1;
        push_one(4'b1001);
        run_idle();
        check_output("after_rst.count", answered_count, 8'd1);
        check_output("after_rst.ans", last_hs_data, 4'b1010);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            q_valid = 1'($urandom_range(0, 1));
            q_data  = 4'($urandom);
            a_ready = ($urandom_range(0, 3) != 0);
            corrupt = ($urandom_range(0, 7) == 0);
            apply_stimulus();
        end
        q_valid = 1'b0;
        corrupt = 1'b0;
        a_ready = 1'b1;
        run_idle();

        // Saturation of the answer counter.
        q_valid = 1'b1;
        n = 0;
        while (m_hs < 300 && n < 5000) begin
            q_data = 4'($urandom);
            apply_stimulus();
            n++;
        end
        q_valid = 1'b0;
        if (m_hs < 300) timeout_fail("saturation");
        run_idle();
        check_output("sat.count", answered_count, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
